data_sync: RTL and testbench

- Destination-domain multi-bit data synchronizer; successor to the single-bit multi-flop synchronizer.
- Brings an asynchronous enable/strobe into the CLK domain through a parametrised NUM_STAGES flop chain.
- Detects an event on that strobe (level-edge or toggle mode) and captures a quasi-static BUS_WIDTH data bus on that event.
- Outputs a one-cycle ENABLE_PULSE and keeps a wrap-around count of captures. Sits at every CDC crossing that carries a multi-bit word.

---
 rtl/data_sync_pkg.sv | 31 +++
 rtl/sync_chain.sv | 32 +++
 rtl/data_sync.sv | 96 +++++++++
 tb/tb_data_sync.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the data_sync multi-bit CDC capture block.
package data_sync_pkg;

  // Event detection modes for the synchronized enable.
  localparam int EN_MODE_LEVEL  = 0;
  localparam int EN_MODE_TOGGLE = 1;

  // Legal synchronizer depth range.
  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;

  // True when a requested synchronizer depth is usable.
  function automatic bit stages_legal(input int n);
    return (n >= MIN_STAGES) && (n <= MAX_STAGES);
  endfunction

  // True when a mode selector names one of the two supported modes.
  function automatic bit mode_legal(input int mode);
    return (mode == EN_MODE_LEVEL) || (mode == EN_MODE_TOGGLE);
  endfunction

  // Event on the synchronized enable: rising edge in LEVEL mode, any
  // change in TOGGLE mode. prev is the previous synchronized value.
  function automatic logic detect_event(input int mode, input logic cur, input logic prev);
    if (mode == EN_MODE_TOGGLE) begin
      return cur ^ prev;
    end
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer: NUM_STAGES back-to-back flops, no logic
// between stages, asynchronous active-high reset to zero.
module sync_chain #(
  parameter int NUM_STAGES = 2,
  parameter int WIDTH      = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [NUM_STAGES];

  // Shift the asynchronous input through the flop chain; stage 0 absorbs
  // any metastability.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// Destination-domain multi-bit data synchronizer. The strobe ASYNC_EN is
// brought into the CLK domain through a flop chain; an event on the
// synchronized strobe captures the quasi-static UNSYNC_BUS, fires a
// one-cycle ENABLE_PULSE and bumps a wrap-around capture counter. The data
// bus itself is never multi-flopped: the source must hold it stable from
// the strobe event until the capture edge.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int EN_MODE    = 0,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 ASYNC_EN,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic [CNT_WIDTH-1:0] CAPTURE_CNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Refuse to build with a depth that cannot give a safe MTBF or that the
  // latency budget does not allow.
  if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
    $fatal(1, "data_sync: NUM_STAGES=%0d outside %0d..%0d",
           NUM_STAGES, MIN_STAGES, MAX_STAGES);
  end

  if (!mode_legal(EN_MODE)) begin : g_bad_mode
    $fatal(1, "data_sync: EN_MODE=%0d is neither LEVEL(0) nor TOGGLE(1)", EN_MODE);
  end

  logic                 en_sync;
  logic                 pg_q;
  logic                 evt_d;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic [BUS_WIDTH-1:0] sync_bus_d;
  logic                 pulse_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  sync_chain #(
    .NUM_STAGES (NUM_STAGES),
    .WIDTH      (1)
  ) u_en_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (ASYNC_EN),
    .q_o   (en_sync)
  );

  // Remember the last synchronized strobe value for edge/toggle detection.
  // Clearing it on reset makes a strobe already high at release count as an
  // event in both modes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pg_q <= 1'b0;
    end else begin
      pg_q <= en_sync;
    end
  end

  // Event detection and next-state for the capture register and counter.
  always_comb begin
    evt_d      = detect_event(EN_MODE, en_sync, pg_q);
    sync_bus_d = sync_bus_q;
    cnt_d      = cnt_q;
    if (evt_d) begin
      sync_bus_d = UNSYNC_BUS;
      cnt_d      = cnt_q + CNT_ONE;
    end
  end

  // Capture data, register the event as the output pulse and count
  // captures; the counter wraps silently.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_bus_q <= '0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_bus_q <= sync_bus_d;
      pulse_q    <= evt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign SYNC_BUS     = sync_bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign CAPTURE_CNT  = cnt_q;

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: four instances (LEVEL depth 2, TOGGLE depth 2,
// LEVEL depth 3, LEVEL depth 4) share the clock, reset and data bus.
// Each strobe event pushes the expected capture (due cycle, data, count)
// onto a scoreboard; a negedge monitor pops it when the pulse appears.
module tb_data_sync;

  localparam int NDUT = 4;
  localparam int STG [NDUT] = '{2, 2, 3, 4};

  typedef struct {
    int         dut;
    int         due;
    logic [7:0] data;
    logic [3:0] cnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] bus;
  logic       en_l;
  logic       en_t;

  logic [7:0] sb [NDUT];
  logic       pl [NDUT];
  logic [3:0] cn [NDUT];

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       exp_q [$];
  logic [3:0] cnt_m     [NDUT];
  logic [7:0] last_bus  [NDUT];
  logic [3:0] last_cnt  [NDUT];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .EN_MODE(0), .CNT_WIDTH(4)) u_lvl2 (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(bus), .ASYNC_EN(en_l),
    .SYNC_BUS(sb[0]), .ENABLE_PULSE(pl[0]), .CAPTURE_CNT(cn[0]));

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .EN_MODE(1), .CNT_WIDTH(4)) u_tgl2 (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(bus), .ASYNC_EN(en_t),
    .SYNC_BUS(sb[1]), .ENABLE_PULSE(pl[1]), .CAPTURE_CNT(cn[1]));

  data_sync #(.NUM_STAGES(3), .BUS_WIDTH(8), .EN_MODE(0), .CNT_WIDTH(4)) u_lvl3 (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(bus), .ASYNC_EN(en_l),
    .SYNC_BUS(sb[2]), .ENABLE_PULSE(pl[2]), .CAPTURE_CNT(cn[2]));

  data_sync #(.NUM_STAGES(4), .BUS_WIDTH(8), .EN_MODE(0), .CNT_WIDTH(4)) u_lvl4 (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(bus), .ASYNC_EN(en_l),
    .SYNC_BUS(sb[3]), .ENABLE_PULSE(pl[3]), .CAPTURE_CNT(cn[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance n rising edges, then settle 2 ns past the edge for driving.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Strobe event driven now (after edge cyc) is sampled at edge cyc+1 and
  // must show up as a pulse after edge cyc+1+NUM_STAGES.
  task automatic push_evt(input int d);
    exp_t e;
    cnt_m[d] = cnt_m[d] + 4'd1;
    e.dut  = d;
    e.due  = cyc + 1 + STG[d];
    e.data = bus;
    e.cnt  = cnt_m[d];
    exp_q.push_back(e);
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int d = 0; d < NDUT; d++) begin
      cnt_m[d]    = '0;
      last_bus[d] = '0;
      last_cnt[d] = '0;
    end
  endtask

  // Scoreboard monitor: pulses must match the oldest pending capture of
  // their instance exactly on its due cycle; outputs otherwise hold.
  always @(negedge CLK) begin
    int idx;
    for (int d = 0; d < NDUT; d++) begin
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (idx < 0 && exp_q[i].dut == d) idx = i;
      end
      if (pl[d]) begin
        if (idx < 0) begin
          chk($sformatf("extra_pulse[%0d]", d), {31'd0, pl[d]}, 32'd0);
        end else begin
          chk($sformatf("pulse_cycle[%0d]", d), cyc, exp_q[idx].due);
          last_bus[d] = exp_q[idx].data;
          last_cnt[d] = exp_q[idx].cnt;
          exp_q.delete(idx);
        end
      end else if (idx >= 0 && exp_q[idx].due <= cyc) begin
        chk($sformatf("missing_pulse[%0d]", d), {31'd0, pl[d]}, 32'd1);
        last_bus[d] = exp_q[idx].data;
        last_cnt[d] = exp_q[idx].cnt;
        exp_q.delete(idx);
      end
      chk($sformatf("sync_bus[%0d]", d), {24'd0, sb[d]}, {24'd0, last_bus[d]});
      chk($sformatf("capture_cnt[%0d]", d), {28'd0, cn[d]}, {28'd0, last_cnt[d]});
    end
  end

  initial begin
    RST  = 1'b1;
    en_l = 1'b0;
    en_t = 1'b0;
    bus  = 8'h00;
    clear_model();

    step(3);
    RST = 1'b0;
    step(3);

    // LEVEL capture held high for 10 cycles: one pulse per level instance
    bus  = 8'hA5;
    en_l = 1'b1;
    push_evt(0);
    push_evt(2);
    push_evt(3);
    step(10);

    // Data change without an event must not reach SYNC_BUS
    bus = 8'h3C;
    step(8);
    chk("hold_bus", {24'd0, sb[0]}, 32'h0000_00A5);
    chk("hold_pulse", {31'd0, pl[0]}, 32'd0);
    en_l = 1'b0;
    step(3);

    // TOGGLE mode: four toggles, five cycles apart, data 01..04
    for (int k = 1; k <= 4; k++) begin
      bus  = 8'(k);
      en_t = ~en_t;
      push_evt(1);
      step(5);
    end
    step(2);
    chk("tgl_cnt", {28'd0, cn[1]}, 32'd4);
    chk("tgl_bus", {24'd0, sb[1]}, 32'h0000_0004);

    // Reset mid-cycle with events in flight: outputs clear at once
    bus  = 8'h5A;
    en_l = 1'b1;
    en_t = 1'b1;
    step(1);
    #1 RST = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_bus[%0d]", d), {24'd0, sb[d]}, 32'd0);
      chk($sformatf("rst_pulse[%0d]", d), {31'd0, pl[d]}, 32'd0);
      chk($sformatf("rst_cnt[%0d]", d), {28'd0, cn[d]}, 32'd0);
    end
    clear_model();
    step(2);

    // Release with the strobe already high: one capture per instance
    RST = 1'b0;
    for (int d = 0; d < NDUT; d++) push_evt(d);
    step(7);
    en_l = 1'b0;
    step(3);

    // Counter wrap on the level instances: 15 more events reach 0, one more gives 1
    for (int i = 0; i < 16; i++) begin
      bus  = 8'h10 + 8'(i);
      en_l = 1'b1;
      push_evt(0);
      push_evt(2);
      push_evt(3);
      step(6);
      en_l = 1'b0;
      step(2);
      if (i == 14) chk("wrap_zero", {28'd0, cn[3]}, 32'd0);
    end
    chk("wrap_one", {28'd0, cn[3]}, 32'd1);
    chk("wrap_bus", {24'd0, sb[0]}, 32'h0000_001F);

    step(8);
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
